// File: rtl/touch_emu_pkg.sv
// Shared state encoding, channel codes and command-byte layout for the
// touch ADC emulator.
`timescale 1ns/1ps
package touch_emu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_BUSY,
        ST_DATA
    } emu_state_t;

    localparam logic [2:0] CH_X  = 3'b101;
    localparam logic [2:0] CH_Y  = 3'b001;
    localparam logic [2:0] CH_Z1 = 3'b011;
    localparam logic [2:0] CH_Z2 = 3'b100;

    localparam int unsigned CMD_START = 7;
    localparam int unsigned CMD_A_HI  = 6;
    localparam int unsigned CMD_A_LO  = 4;
    localparam int unsigned CMD_MODE  = 3;
    localparam int unsigned CMD_SER   = 2;
    localparam int unsigned CMD_PD_HI = 1;
    localparam int unsigned CMD_PD_LO = 0;

    // PD1:PD0 = 11 keeps the panel biased, which masks the pen interrupt.
    function automatic logic pd_allows_irq(input logic [7:0] cmd);
        return cmd[CMD_PD_HI:CMD_PD_LO] != 2'b11;
    endfunction

endpackage

// File: rtl/touch_adc_emulator_sync_edge.sv
// Multi-flop synchronizer (touch_sync) and a synchronizer with one-cycle
// rise/fall pulses on the synchronized level (touch_sync_edge).
`timescale 1ns/1ps
module touch_sync #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RST_VAL}};
        end else begin
            r_sync <= (r_sync << 1) | STAGES'(i_d);
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

module touch_sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic w_q;
    logic r_prev;

    touch_sync #(
        .STAGES  (STAGES),
        .RST_VAL (RST_VAL)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (i_d),
        .o_q   (w_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= RST_VAL;
        end else begin
            r_prev <= w_q;
        end
    end

    assign o_q    = w_q;
    assign o_rise = w_q & ~r_prev;
    assign o_fall = ~w_q & r_prev;

endmodule

// File: rtl/touch_adc_emulator.sv
// SPI responder emulating a resistive-touch ADC; results come from register inputs.
// Optional pen-interrupt output enabled with `define TOUCH_EMU_PENIRQ_EN.
`timescale 1ns/1ps
module touch_adc_emulator
    import touch_emu_pkg::*;
#(
    parameter int unsigned       DATA_W      = 12,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] PEN_THRESH  = 12'd256
) (
    input  logic              cclk,
    input  logic              rstb,
    input  logic              touch_clk,
    input  logic              touch_csb,
    input  logic              touch_data_in,
    output logic              touch_busy,
    output logic              touch_data_out,
    input  logic [DATA_W-1:0] x_val,
    input  logic [DATA_W-1:0] y_val,
    input  logic [DATA_W-1:0] z1_val,
    input  logic [DATA_W-1:0] z2_val,
    output logic              cmd_strobe,
    output logic [7:0]        last_cmd
`ifdef TOUCH_EMU_PENIRQ_EN
    ,
    output logic              touch_penirq_n
`endif
);

    localparam int unsigned CNT_W = (DATA_W > 8) ? $clog2(DATA_W + 1) : 4;

    logic w_dclk_rise;
    logic w_dclk_fall;
    logic w_dclk_unused;
    logic w_csb;
    logic w_din;

    touch_sync_edge #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_sync_dclk (
        .clk    (cclk),
        .rst_n  (rstb),
        .i_d    (touch_clk),
        .o_q    (w_dclk_unused),
        .o_rise (w_dclk_rise),
        .o_fall (w_dclk_fall)
    );

    touch_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync_csb (
        .clk   (cclk),
        .rst_n (rstb),
        .i_d   (touch_csb),
        .o_q   (w_csb)
    );

    touch_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_sync_din (
        .clk   (cclk),
        .rst_n (rstb),
        .i_d   (touch_data_in),
        .o_q   (w_din)
    );

    emu_state_t        r_state;
    logic [6:0]        r_cmd;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_snap;
    logic              r_mode8;
    logic              r_busy;
    logic              r_dout;
    logic              r_strobe;
    logic [7:0]        r_last_cmd;

    logic [7:0]        w_cmd_next;
    logic [DATA_W-1:0] w_sel;
    logic [CNT_W-1:0]  w_nbits;

    assign w_cmd_next = {r_cmd, w_din};
    assign w_nbits    = r_mode8 ? CNT_W'(8) : CNT_W'(DATA_W);

    always_comb begin
        w_sel = '0;
        case (w_cmd_next[CMD_A_HI:CMD_A_LO])
            CH_X:    w_sel = x_val;
            CH_Y:    w_sel = y_val;
            CH_Z1:   w_sel = z1_val;
            CH_Z2:   w_sel = z2_val;
            default: w_sel = '0;
        endcase
    end

    // Deselect has priority over any DCLK edge seen in the same cycle.
    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            r_state    <= ST_IDLE;
            r_cmd      <= '0;
            r_cnt      <= '0;
            r_snap     <= '0;
            r_mode8    <= 1'b0;
            r_busy     <= 1'b0;
            r_dout     <= 1'b0;
            r_strobe   <= 1'b0;
            r_last_cmd <= '0;
        end else begin
            r_strobe <= 1'b0;
            if (w_csb) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_dout  <= 1'b0;
                r_cnt   <= '0;
                r_cmd   <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_dclk_rise && w_din) begin
                            r_cmd   <= 7'd1;
                            r_cnt   <= CNT_W'(1);
                            r_state <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        if (w_dclk_rise) begin
                            r_cmd <= w_cmd_next[6:0];
                            if (r_cnt == CNT_W'(7)) begin
                                r_last_cmd <= w_cmd_next;
                                r_strobe   <= 1'b1;
                                r_snap     <= w_sel;
                                r_mode8    <= w_cmd_next[CMD_MODE];
                                r_cnt      <= '0;
                                r_state    <= ST_BUSY;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    ST_BUSY: begin
                        if (w_dclk_fall) begin
                            if (!r_busy) begin
                                r_busy <= 1'b1;
                            end else begin
                                r_busy  <= 1'b0;
                                r_dout  <= r_snap[DATA_W-1];
                                r_snap  <= r_snap << 1;
                                r_cnt   <= CNT_W'(1);
                                r_state <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        // r_cnt counts bits already presented on DOUT.
                        if (w_dclk_fall) begin
                            if (r_cnt == w_nbits) begin
                                r_dout  <= 1'b0;
                                r_cnt   <= '0;
                                r_state <= ST_IDLE;
                            end else begin
                                r_dout <= r_snap[DATA_W-1];
                                r_snap <= r_snap << 1;
                                r_cnt  <= r_cnt + 1'b1;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign touch_busy     = r_busy;
    assign touch_data_out = r_dout;
    assign cmd_strobe     = r_strobe;
    assign last_cmd       = r_last_cmd;

`ifdef TOUCH_EMU_PENIRQ_EN
    logic r_penirq_n;

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            r_penirq_n <= 1'b1;
        end else begin
            r_penirq_n <= !((r_state == ST_IDLE) && (z1_val > PEN_THRESH)
                            && pd_allows_irq(r_last_cmd));
        end
    end

    assign touch_penirq_n = r_penirq_n;
`endif

endmodule

// File: tb/tb_touch_adc_emulator.sv
// Scoreboard bench for touch_adc_emulator: stimulus queues expected DOUT/BUSY
// per DCLK rise and expected command bytes; monitors pop and compare.
`timescale 1ns/1ps
module tb_touch_adc_emulator;

    localparam int unsigned HALF = 8;
    localparam int unsigned SYNC = 2;

    logic        cclk = 1'b0;
    logic        rstb = 1'b0;
    logic        touch_clk = 1'b0;
    logic        touch_csb = 1'b1;
    logic        touch_data_in = 1'b0;
    logic        touch_busy;
    logic        touch_data_out;
    logic        cmd_strobe;
    logic [7:0]  last_cmd;
    logic [11:0] x_val = '0;
    logic [11:0] y_val = '0;
    logic [11:0] z1_val = '0;
    logic [11:0] z2_val = '0;
`ifdef TOUCH_EMU_PENIRQ_EN
    logic        penirq_n;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic busy;
        logic dout;
    } exp_t;

    exp_t       q_exp[$];
    logic [7:0] q_cmd[$];
    exp_t       e_mon;

    always #5 cclk = ~cclk;

    touch_adc_emulator #(
        .DATA_W      (12),
        .SYNC_STAGES (SYNC),
        .PEN_THRESH  (12'd256)
    ) dut (
        .cclk           (cclk),
        .rstb           (rstb),
        .touch_clk      (touch_clk),
        .touch_csb      (touch_csb),
        .touch_data_in  (touch_data_in),
        .touch_busy     (touch_busy),
        .touch_data_out (touch_data_out),
        .x_val          (x_val),
        .y_val          (y_val),
        .z1_val         (z1_val),
        .z2_val         (z2_val),
        .cmd_strobe     (cmd_strobe),
        .last_cmd       (last_cmd)
`ifdef TOUCH_EMU_PENIRQ_EN
        ,
        .touch_penirq_n (penirq_n)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic ncyc(input int unsigned n);
        repeat (n) @(negedge cclk);
    endtask

    // Controller samples DOUT/BUSY on DCLK rise; every rise with CS low must have an expectation.
    always @(posedge touch_clk) begin
        #1;
        if (!touch_csb && rstb) begin
            if (q_exp.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dclk_rise_unexpected: got rise expected none at %0t", $time);
            end else begin
                e_mon = q_exp.pop_front();
                chk("busy", 32'(touch_busy), 32'(e_mon.busy));
                chk("dout", 32'(touch_data_out), 32'(e_mon.dout));
            end
        end
    end

    always @(negedge cclk) begin
        if (rstb && cmd_strobe) begin
            if (q_cmd.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL cmd_strobe_extra: got strobe last_cmd=%0h expected none", last_cmd);
            end else begin
                chk("last_cmd", 32'(last_cmd), 32'(q_cmd.pop_front()));
            end
        end
    end

    // mode 0: full transfer; 1: CS abort at rise stop_q; 2: reset at rise stop_q.
    task automatic xfer(input logic [7:0] cmd, input int lead, input logic [11:0] val,
                        input int nbits, input int mode, input int stop_q);
        int   total;
        int   q;
        exp_t e;
        total = lead + 10 + nbits;
        q_cmd.push_back(cmd);
        touch_csb = 1'b0;
        ncyc(HALF);
        for (int p = 0; p < total; p++) begin
            q = p - lead;
            touch_data_in = (q >= 0 && q < 8) ? cmd[7-q] : 1'b0;
            e.busy = (q == 8);
            e.dout = (q >= 9 && q < 9 + nbits) ? val[11-(q-9)] : 1'b0;
            q_exp.push_back(e);
            ncyc(HALF);
            touch_clk = 1'b1;
            if (mode != 0 && q == stop_q) begin
                ncyc(1);
                if (mode == 1) begin
                    touch_csb = 1'b1;
                    repeat (SYNC + 1) @(posedge cclk);
                    #1;
                    chk("abort_busy", 32'(touch_busy), 0);
                    chk("abort_dout", 32'(touch_data_out), 0);
                end else begin
                    #2 rstb = 1'b0;
                    #1;
                    chk("rst_busy", 32'(touch_busy), 0);
                    chk("rst_dout", 32'(touch_data_out), 0);
                    chk("rst_last_cmd", 32'(last_cmd), 0);
                end
                ncyc(HALF);
                touch_clk     = 1'b0;
                touch_data_in = 1'b0;
                touch_csb     = 1'b1;
                ncyc(4);
                rstb = 1'b1;
                ncyc(2 * HALF);
                return;
            end
            ncyc(HALF);
            touch_clk = 1'b0;
        end
        touch_data_in = 1'b0;
        ncyc(HALF);
        touch_csb = 1'b1;
        ncyc(2 * HALF);
    endtask

    initial begin
        ncyc(3);
        chk("reset_busy", 32'(touch_busy), 0);
        chk("reset_dout", 32'(touch_data_out), 0);
        chk("reset_strobe", 32'(cmd_strobe), 0);
        chk("reset_last_cmd", 32'(last_cmd), 0);
        rstb = 1'b1;
        ncyc(4);

        // Reset while the fifth data bit is on DOUT, then a normal X read.
        x_val = 12'hFFF;
        xfer(8'hD0, 0, 12'hFFF, 12, 2, 13);
        x_val = 12'hA5C;
        xfer(8'hD0, 0, 12'hA5C, 12, 0, 0);

        y_val = 12'h3F0;
        xfer(8'h98, 0, 12'h3F0, 8, 0, 0);

        x_val = 12'hFFF; y_val = 12'hFFF; z1_val = 12'hFFF; z2_val = 12'hFFF;
        xfer(8'hA0, 3, 12'h000, 12, 0, 0);

        x_val = 12'hB5C;
        xfer(8'hD0, 0, 12'hB5C, 12, 1, 12);
        z1_val = 12'h123;
        xfer(8'hB0, 0, 12'h123, 12, 0, 0);

        z2_val = 12'h6C9;
        xfer(8'hC0, 0, 12'h6C9, 12, 0, 0);

        x_val = 12'hFFF;
        fork
            xfer(8'hD0, 0, 12'hFFF, 12, 0, 0);
            begin
                ncyc(190);
                x_val = 12'h000;
            end
        join

`ifdef TOUCH_EMU_PENIRQ_EN
        z1_val = 12'd300;
        ncyc(4);
        chk("penirq_idle_down", 32'(penirq_n), 0);
        fork
            xfer(8'hB0, 0, 12'd300, 12, 0, 0);
            begin
                ncyc(120);
                chk("penirq_xfer_high", 32'(penirq_n), 1);
            end
        join
        ncyc(4);
        chk("penirq_idle_again", 32'(penirq_n), 0);
        z1_val = 12'd100;
        ncyc(4);
        chk("penirq_below_thresh", 32'(penirq_n), 1);
`endif

        ncyc(10);
        chk("exp_queue_drained", 32'(q_exp.size()), 0);
        chk("cmd_queue_drained", 32'(q_cmd.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
